i2c_eeprom_ctrl: RTL and testbench

I2C master controller that sequences single-byte random writes and random reads to an AT24C64-class serial EEPROM (13-bit word address, two address bytes). It sits between on-chip logic and the two-wire bus. A simple start/done handshake drives it, and it generates SCL and open-drain SDA. It produces the full START / control / address / data / ACK / STOP protocol, including the repeated START for reads, and flags a missing acknowledge.

---
 rtl/i2c_eeprom_ctrl.sv | 273 +++++++++++++++++++++++++++
 tb/tb_i2c_eeprom_ctrl.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_eeprom_ctrl.sv
`timescale 1ns/1ps
// i2c_eeprom_ctrl
// I2C master that performs single-byte random writes and random reads on an
// AT24C64-class EEPROM (13-bit word address sent as two bytes).
//
// Ports:
//   clk, rst_n      system clock, asynchronous active-low reset
//   start           one-cycle request, sampled only while idle
//   rw              0 = write, 1 = read (captured with start)
//   addr[12:0]      EEPROM word address (captured with start)
//   wdata[7:0]      write data (captured with start)
//   rdata[7:0]      read result, updated only by a fully acknowledged read
//   busy            high from the cycle after start until done
//   done            one-cycle pulse at the end of every transaction
//   ack_err         valid with done, 1 = a slave ACK slot was NACKed
//   scl             push-pull I2C clock
//   sda             open-drain I2C data (driven 0 or released)
//
// Each bus symbol (START, bit, RESTART, STOP) spans four quarter periods of
// CLK_DIV clocks. Bus levels are decoded from state/phase and registered;
// SDA is registered one extra clock behind SCL so that SDA never moves on
// the same clock as an SCL edge.
module i2c_eeprom_ctrl #(
  parameter int         CLK_DIV = 125,
  parameter logic [2:0] DEV_SEL = 3'b000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        rw,
  input  logic [12:0] addr,
  input  logic [7:0]  wdata,
  output logic [7:0]  rdata,
  output logic        busy,
  output logic        done,
  output logic        ack_err,
  output logic        scl,
  inout  wire         sda
);

  localparam int DIV_W = $clog2(CLK_DIV);
  localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(CLK_DIV - 1);

  typedef enum logic [3:0] {
    ST_IDLE    = 4'd0,
    ST_START   = 4'd1,
    ST_SEND    = 4'd2,
    ST_ACK_CHK = 4'd3,
    ST_RESTART = 4'd4,
    ST_RECV    = 4'd5,
    ST_MNACK   = 4'd6,
    ST_STOP    = 4'd7,
    ST_DONE    = 4'd8
  } state_t;

  state_t            state_r;
  logic [DIV_W-1:0]  div_r;
  logic [1:0]        phase_r;
  logic [2:0]        bit_cnt_r;
  logic [1:0]        byte_idx_r;
  logic [7:0]        shift_r;
  logic              rw_r;
  logic [12:0]       addr_r;
  logic [7:0]        wdata_r;
  logic              err_r;
  logic              ack_bit_r;
  logic              sda_pre_r;
  logic              sda_low_r;
  logic              tick_s;
  logic              scl_nxt_s;
  logic              sda_nxt_s;

  // Byte sent in each slot: ctrl(W), addr_hi, addr_lo, then wdata or ctrl(R).
  function automatic logic [7:0] byte_sel(input logic [1:0]  idx,
                                          input logic        rw_b,
                                          input logic [12:0] addr_b,
                                          input logic [7:0]  wdata_b);
    logic [7:0] b;
    case (idx)
      2'd0:    b = {4'b1010, DEV_SEL, 1'b0};
      2'd1:    b = {3'b000, addr_b[12:8]};
      2'd2:    b = addr_b[7:0];
      2'd3:    b = rw_b ? {4'b1010, DEV_SEL, 1'b1} : wdata_b;
      default: b = 8'h00;
    endcase
    return b;
  endfunction

  assign tick_s = (div_r == DIV_MAX);
  assign sda    = sda_low_r ? 1'b0 : 1'bz;

  // Transaction sequencer: quarter divider, phase, bit/byte counters, status.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= ST_IDLE;
      div_r      <= '0;
      phase_r    <= 2'd0;
      bit_cnt_r  <= 3'd0;
      byte_idx_r <= 2'd0;
      shift_r    <= 8'h00;
      rw_r       <= 1'b0;
      addr_r     <= 13'h0000;
      wdata_r    <= 8'h00;
      err_r      <= 1'b0;
      ack_bit_r  <= 1'b0;
      rdata      <= 8'h00;
      busy       <= 1'b0;
      done       <= 1'b0;
      ack_err    <= 1'b0;
    end else begin
      done  <= 1'b0;
      div_r <= tick_s ? '0 : div_r + 1'b1;
      if (tick_s) begin
        phase_r <= phase_r + 2'd1;
      end
      case (state_r)
        ST_IDLE: begin
          div_r      <= '0;
          phase_r    <= 2'd0;
          bit_cnt_r  <= 3'd0;
          byte_idx_r <= 2'd0;
          if (start) begin
            rw_r    <= rw;
            addr_r  <= addr;
            wdata_r <= wdata;
            err_r   <= 1'b0;
            busy    <= 1'b1;
            state_r <= ST_START;
          end
        end
        ST_START, ST_RESTART: begin
          if (tick_s && phase_r == 2'd3) begin
            shift_r   <= byte_sel(byte_idx_r, rw_r, addr_r, wdata_r);
            bit_cnt_r <= 3'd0;
            state_r   <= ST_SEND;
          end
        end
        ST_SEND: begin
          if (tick_s && phase_r == 2'd3) begin
            if (bit_cnt_r == 3'd7) begin
              bit_cnt_r <= 3'd0;
              state_r   <= ST_ACK_CHK;
            end else begin
              shift_r   <= {shift_r[6:0], 1'b0};
              bit_cnt_r <= bit_cnt_r + 3'd1;
            end
          end
        end
        ST_ACK_CHK: begin
          if (tick_s && phase_r == 2'd2) begin
            ack_bit_r <= sda;
          end
          if (tick_s && phase_r == 2'd3) begin
            if (ack_bit_r) begin
              // NACK: abandon the remaining bytes and close the bus.
              err_r   <= 1'b1;
              state_r <= ST_STOP;
            end else begin
              case (byte_idx_r)
                2'd0, 2'd1: begin
                  byte_idx_r <= byte_idx_r + 2'd1;
                  shift_r    <= byte_sel(byte_idx_r + 2'd1, rw_r, addr_r, wdata_r);
                  state_r    <= ST_SEND;
                end
                2'd2: begin
                  byte_idx_r <= 2'd3;
                  if (rw_r) begin
                    state_r <= ST_RESTART;
                  end else begin
                    shift_r <= byte_sel(2'd3, rw_r, addr_r, wdata_r);
                    state_r <= ST_SEND;
                  end
                end
                default: begin
                  state_r <= rw_r ? ST_RECV : ST_STOP;
                end
              endcase
            end
          end
        end
        ST_RECV: begin
          if (tick_s && phase_r == 2'd2) begin
            shift_r <= {shift_r[6:0], sda};
          end
          if (tick_s && phase_r == 2'd3) begin
            if (bit_cnt_r == 3'd7) begin
              bit_cnt_r <= 3'd0;
              state_r   <= ST_MNACK;
            end else begin
              bit_cnt_r <= bit_cnt_r + 3'd1;
            end
          end
        end
        ST_MNACK: begin
          if (tick_s && phase_r == 2'd3) begin
            rdata   <= shift_r;
            state_r <= ST_STOP;
          end
        end
        ST_STOP: begin
          if (tick_s && phase_r == 2'd3) begin
            state_r <= ST_DONE;
          end
        end
        ST_DONE: begin
          done    <= 1'b1;
          busy    <= 1'b0;
          ack_err <= err_r;
          state_r <= ST_IDLE;
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  // Bus level decode for the current symbol quarter (sda_nxt_s = pull low).
  always_comb begin
    scl_nxt_s = 1'b1;
    sda_nxt_s = 1'b0;
    case (state_r)
      ST_START: begin
        case (phase_r)
          2'd2:    begin scl_nxt_s = 1'b1; sda_nxt_s = 1'b1; end
          2'd3:    begin scl_nxt_s = 1'b0; sda_nxt_s = 1'b1; end
          default: begin scl_nxt_s = 1'b1; sda_nxt_s = 1'b0; end
        endcase
      end
      ST_SEND: begin
        scl_nxt_s = phase_r[1];
        sda_nxt_s = ~shift_r[7];
      end
      ST_ACK_CHK, ST_RECV, ST_MNACK: begin
        scl_nxt_s = phase_r[1];
        sda_nxt_s = 1'b0;
      end
      ST_RESTART: begin
        case (phase_r)
          2'd0:    begin scl_nxt_s = 1'b0; sda_nxt_s = 1'b0; end
          2'd1:    begin scl_nxt_s = 1'b1; sda_nxt_s = 1'b0; end
          2'd2:    begin scl_nxt_s = 1'b1; sda_nxt_s = 1'b1; end
          default: begin scl_nxt_s = 1'b0; sda_nxt_s = 1'b1; end
        endcase
      end
      ST_STOP: begin
        case (phase_r)
          2'd0:    begin scl_nxt_s = 1'b0; sda_nxt_s = 1'b1; end
          2'd1:    begin scl_nxt_s = 1'b1; sda_nxt_s = 1'b1; end
          default: begin scl_nxt_s = 1'b1; sda_nxt_s = 1'b0; end
        endcase
      end
      default: begin
        scl_nxt_s = 1'b1;
        sda_nxt_s = 1'b0;
      end
    endcase
  end

  // Output registers; SDA trails SCL by one clock so data moves while SCL is low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl       <= 1'b1;
      sda_pre_r <= 1'b0;
      sda_low_r <= 1'b0;
    end else begin
      scl       <= scl_nxt_s;
      sda_pre_r <= sda_nxt_s;
      sda_low_r <= sda_pre_r;
    end
  end

endmodule

// File: tb/tb_i2c_eeprom_ctrl.sv
`timescale 1ns/1ps
// Directed bench for i2c_eeprom_ctrl with a behavioural AT24C64-style slave.
module tb_i2c_eeprom_ctrl;

  localparam int C      = 4;
  localparam int W_CLKS = 152 * C + 2;
  localparam int R_CLKS = 192 * C + 2;
  localparam int N_CLKS = 44 * C + 2;

  logic clk = 1'b0;
  logic rst_n;

  logic        start1, rw1, busy1, done1, ack_err1;
  logic [12:0] addr1;
  logic [7:0]  wdata1, rdata1;
  wire         scl1, sda1;

  logic        start2, rw2, busy2, done2, ack_err2;
  logic [12:0] addr2;
  logic [7:0]  wdata2, rdata2;
  wire         scl2, sda2;

  pullup (sda1);
  pullup (sda2);

  always #5 clk = ~clk;

  i2c_eeprom_ctrl #(.CLK_DIV(C), .DEV_SEL(3'b000)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .rw(rw1), .addr(addr1),
    .wdata(wdata1), .rdata(rdata1), .busy(busy1), .done(done1),
    .ack_err(ack_err1), .scl(scl1), .sda(sda1)
  );

  i2c_eeprom_ctrl #(.CLK_DIV(C), .DEV_SEL(3'b101)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .rw(rw2), .addr(addr2),
    .wdata(wdata2), .rdata(rdata2), .busy(busy2), .done(done2),
    .ack_err(ack_err2), .scl(scl2), .sda(sda2)
  );

  // ---------------- EEPROM slave model ----------------
  logic       use2;
  logic [2:0] dev;
  logic       slv_low = 1'b0;
  logic [7:0] mem [0:8191];
  wire        m_scl = use2 ? scl2 : scl1;
  wire        m_sda = use2 ? sda2 : sda1;

  assign sda1 = (slv_low && !use2) ? 1'b0 : 1'bz;
  assign sda2 = (slv_low &&  use2) ? 1'b0 : 1'bz;

  logic        p_scl = 1'b1, p_sda = 1'b1;
  int          mode = 0;     // 0 idle, 1 receiving, 2 transmitting
  int          cnt = 0;      // SCL rising edges in the current 9-clock frame
  int          byte_no = 0;
  logic [7:0]  sh = 8'h00, txb = 8'h00;
  logic [12:0] ptr = 13'h0000;
  logic        is_read = 1'b0;
  logic        last_mack = 1'b0;
  int          start_cnt = 0, stop_cnt = 0, ack_cnt = 0, rx_total = 0;
  logic [7:0]  rx_log [0:255];

  always @(m_scl or m_sda) begin
    if (m_scl !== p_scl) begin
      if (m_scl === 1'b1) begin
        if (mode != 0) begin
          cnt = cnt + 1;
          if (mode == 1 && cnt <= 8) sh = {sh[6:0], m_sda};
          if (mode == 2 && cnt == 9) last_mack = m_sda;
        end
      end else if (mode == 1) begin
        if (cnt == 8) begin
          if (rx_total < 256) rx_log[rx_total] = sh;
          rx_total = rx_total + 1;
          if (byte_no == 0) begin
            if (sh[7:1] == {4'b1010, dev}) begin
              is_read = sh[0]; slv_low = 1'b1; ack_cnt = ack_cnt + 1;
            end else begin
              mode = 0; slv_low = 1'b0;
            end
          end else begin
            if (byte_no == 1)      ptr[12:8] = sh[4:0];
            else if (byte_no == 2) ptr[7:0]  = sh;
            else begin mem[ptr] = sh; ptr = ptr + 13'd1; end
            slv_low = 1'b1; ack_cnt = ack_cnt + 1;
          end
          byte_no = byte_no + 1;
        end else if (cnt == 9) begin
          cnt = 0; slv_low = 1'b0;
          if (is_read && byte_no == 1) begin
            mode = 2; txb = mem[ptr]; slv_low = ~txb[7];
          end
        end
      end else if (mode == 2) begin
        if (cnt >= 1 && cnt <= 7) slv_low = ~txb[7-cnt];
        else if (cnt == 8) slv_low = 1'b0;
        else if (cnt == 9) begin
          cnt = 0;
          if (last_mack) mode = 0;
          else begin ptr = ptr + 13'd1; txb = mem[ptr]; slv_low = ~txb[7]; end
        end
      end
    end else if (m_sda !== p_sda && m_scl === 1'b1) begin
      if (m_sda === 1'b0) begin
        start_cnt = start_cnt + 1; mode = 1; cnt = 0; byte_no = 0; slv_low = 1'b0;
      end else begin
        stop_cnt = stop_cnt + 1; mode = 0; slv_low = 1'b0;
      end
    end
    p_scl = m_scl;
    p_sda = m_sda;
  end

  // ---------------- checking ----------------
  int checks = 0;
  int errors = 0;
  int b_start, b_stop, b_ack, b_rx;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks = checks + 1;
    assert (obs === exp_v) else begin
      errors = errors + 1;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic snap();
    b_start = start_cnt; b_stop = stop_cnt; b_ack = ack_cnt; b_rx = rx_total;
  endtask

  task automatic run_txn(input bit d2, input bit rw_i, input logic [12:0] a,
                         input logic [7:0] wd, input int exp_n, input bit exp_err,
                         input bit dup, input string tag);
    int  n;
    bit  got;
    @(negedge clk);
    if (d2) begin start2 = 1'b1; rw2 = rw_i; addr2 = a; wdata2 = wd; end
    else    begin start1 = 1'b1; rw1 = rw_i; addr1 = a; wdata1 = wd; end
    n = 0; got = 1'b0;
    while (!got && n < exp_n + 50) begin
      @(posedge clk); #1;
      n = n + 1;
      if (n == 1) begin
        start1 = 1'b0; start2 = 1'b0;
        chk({tag, "_busy_rise"}, d2 ? busy2 : busy1, 1);
      end
      if (dup && n == 10) begin start1 = 1'b1; rw1 = ~rw_i; addr1 = 13'h0AAA; end
      if (dup && n == 11) start1 = 1'b0;
      if ((d2 ? done2 : done1) === 1'b1) got = 1'b1;
    end
    chk({tag, "_len"}, n, exp_n);
    chk({tag, "_ack_err"}, d2 ? ack_err2 : ack_err1, exp_err);
    chk({tag, "_busy_fall"}, d2 ? busy2 : busy1, 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL timeout watchdog");
    $fatal(1, "simulation did not finish");
  end

  initial begin
    int extra;
    start1 = 1'b0; rw1 = 1'b0; addr1 = 13'h0; wdata1 = 8'h0;
    start2 = 1'b0; rw2 = 1'b0; addr2 = 13'h0; wdata2 = 8'h0;
    use2 = 1'b0; dev = 3'b000; rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_scl", scl1, 1);
    chk("rst_sda", sda1, 1);
    chk("rst_busy", busy1, 0);
    chk("rst_done", done1, 0);
    chk("rst_ack_err", ack_err1, 0);
    chk("rst_rdata", rdata1, 8'h00);
    @(negedge clk) rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // Write 1A5C <- 3C
    snap();
    run_txn(1'b0, 1'b0, 13'h1A5C, 8'h3C, W_CLKS, 1'b0, 1'b0, "wr1");
    chk("wr1_acks", ack_cnt - b_ack, 4);
    chk("wr1_mem", mem[13'h1A5C], 8'h3C);
    chk("wr1_ctrl", rx_log[b_rx], 8'hA0);
    chk("wr1_starts", start_cnt - b_start, 1);
    chk("wr1_stops", stop_cnt - b_stop, 1);
    repeat (5) @(posedge clk);

    // Read 1A5C back
    snap();
    run_txn(1'b0, 1'b1, 13'h1A5C, 8'h00, R_CLKS, 1'b0, 1'b0, "rd1");
    chk("rd1_rdata", rdata1, 8'h3C);
    chk("rd1_restart", start_cnt - b_start, 2);
    chk("rd1_ctrl_r", rx_log[b_rx + 3], 8'hA1);
    chk("rd1_acks", ack_cnt - b_ack, 4);
    chk("rd1_mnack", last_mack, 1);
    chk("rd1_stops", stop_cnt - b_stop, 1);
    repeat (5) @(posedge clk);

    // Boundary address 1FFF
    snap();
    run_txn(1'b0, 1'b0, 13'h1FFF, 8'hA5, W_CLKS, 1'b0, 1'b0, "wr2");
    chk("wr2_addr_hi", rx_log[b_rx + 1], 8'h1F);
    chk("wr2_addr_lo", rx_log[b_rx + 2], 8'hFF);
    chk("wr2_mem", mem[13'h1FFF], 8'hA5);
    repeat (5) @(posedge clk);
    run_txn(1'b0, 1'b1, 13'h1FFF, 8'h00, R_CLKS, 1'b0, 1'b0, "rd2");
    chk("rd2_rdata", rdata1, 8'hA5);
    repeat (5) @(posedge clk);

    // Second controller with DEV_SEL=101: matching slave first, then mismatch
    use2 = 1'b1; dev = 3'b101;
    snap();
    run_txn(1'b1, 1'b1, 13'h1A5C, 8'h00, R_CLKS, 1'b0, 1'b0, "rd3");
    chk("rd3_ctrl", rx_log[b_rx], 8'hAA);
    chk("rd3_rdata", rdata2, 8'h3C);
    repeat (5) @(posedge clk);
    dev = 3'b000;
    snap();
    run_txn(1'b1, 1'b1, 13'h1A5C, 8'h00, N_CLKS, 1'b1, 1'b0, "nack");
    chk("nack_rdata_kept", rdata2, 8'h3C);
    chk("nack_acks", ack_cnt - b_ack, 0);
    chk("nack_bytes", rx_total - b_rx, 1);
    chk("nack_stops", stop_cnt - b_stop, 1);
    repeat (5) @(posedge clk);
    use2 = 1'b0;
    repeat (5) @(posedge clk);

    // Second start while busy is ignored
    snap();
    run_txn(1'b0, 1'b0, 13'h0123, 8'h77, W_CLKS, 1'b0, 1'b1, "dup");
    extra = 0;
    for (int i = 0; i < 700; i++) begin
      @(posedge clk); #1;
      if (done1 === 1'b1) extra = extra + 1;
    end
    chk("dup_extra_done", extra, 0);
    chk("dup_starts", start_cnt - b_start, 1);
    chk("dup_mem", mem[13'h0123], 8'h77);

    // Reset in the middle of the addr_lo byte
    @(negedge clk);
    start1 = 1'b1; rw1 = 1'b0; addr1 = 13'h0456; wdata1 = 8'h99;
    @(posedge clk); #1;
    start1 = 1'b0;
    repeat (360) @(posedge clk);
    #1;
    chk("mid_busy_pre", busy1, 1);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rst_scl", scl1, 1);
    chk("mid_rst_sda", sda1, 1);
    chk("mid_rst_busy", busy1, 0);
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    repeat (3) @(posedge clk);
    snap();
    run_txn(1'b0, 1'b0, 13'h0456, 8'h5A, W_CLKS, 1'b0, 1'b0, "post");
    chk("post_mem", mem[13'h0456], 8'h5A);
    chk("post_acks", ack_cnt - b_ack, 4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
